// File: rtl/alu_pkg.sv
// Shared ALU definitions: aluop encodings, sequencer status codes and FSM state encoding.
package alu_pkg;

  localparam logic [3:0] OpAdd       = 4'd0;
  localparam logic [3:0] OpSub       = 4'd1;
  localparam logic [3:0] OpMul       = 4'd2;
  localparam logic [3:0] OpDiv       = 4'd3;
  localparam logic [3:0] OpAnd       = 4'd4;
  localparam logic [3:0] OpOr        = 4'd5;
  localparam logic [3:0] OpXor       = 4'd6;
  localparam logic [3:0] OpClo       = 4'd7;
  localparam logic [3:0] OpClz       = 4'd8;
  localparam logic [3:0] OpSll       = 4'd9;
  localparam logic [3:0] OpSrl       = 4'd10;
  localparam logic [3:0] OpSra       = 4'd11;
  localparam logic [3:0] OpRot       = 4'd12;
  localparam logic [3:0] OpLastLegal = 4'd12;

  typedef enum logic [1:0] {
    StatusOk      = 2'd0,
    StatusIllegal = 2'd1,
    StatusTimeout = 2'd2
  } status_e;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StIssue   = 3'd1,
    StWait    = 3'd2,
    StResp    = 3'd3,
    StRelease = 3'd4
  } seq_state_e;

endpackage

// File: rtl/alu_op_sequencer.sv
// Holds one ALU command stable on the ALU, waits for done (after a settle window that masks a
// stale done), and returns the result on a valid/ready response channel.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES  = 2,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [3:0]  cmd_aluop_i,
  input  logic [31:0] cmd_a_i,
  input  logic [31:0] cmd_b_i,
  input  logic        cmd_inverted_i,
  input  logic        cmd_inc_i,
  output logic [3:0]  alu_aluop_o,
  output logic [31:0] alu_a_o,
  output logic [31:0] alu_b_o,
  output logic        alu_output_inverted_o,
  output logic        alu_output_inc_o,
  input  logic        alu_done_i,
  input  logic [31:0] alu_res_high_i,
  input  logic [31:0] alu_res_low_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_high_o,
  output logic [31:0] rsp_low_o,
  output logic [1:0]  rsp_status_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] SettleLast = CntW'(SETTLE_CYCLES - 1);
  localparam logic [CntW-1:0] TimeoutCnt = CntW'(TIMEOUT_CYCLES);

  seq_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      alu_op_q, alu_op_d;
  logic [31:0]     alu_a_q, alu_a_d;
  logic [31:0]     alu_b_q, alu_b_d;
  logic            alu_inv_q, alu_inv_d;
  logic            alu_inc_q, alu_inc_d;
  logic [31:0]     rsp_high_q, rsp_high_d;
  logic [31:0]     rsp_low_q, rsp_low_d;
  status_e         status_q, status_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      alu_op_q   <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_inv_q  <= 1'b0;
      alu_inc_q  <= 1'b0;
      rsp_high_q <= '0;
      rsp_low_q  <= '0;
      status_q   <= StatusOk;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      alu_op_q   <= alu_op_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_inv_q  <= alu_inv_d;
      alu_inc_q  <= alu_inc_d;
      rsp_high_q <= rsp_high_d;
      rsp_low_q  <= rsp_low_d;
      status_q   <= status_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    alu_op_d   = alu_op_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_inv_d  = alu_inv_q;
    alu_inc_d  = alu_inc_q;
    rsp_high_d = rsp_high_q;
    rsp_low_d  = rsp_low_q;
    status_d   = status_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid_i) begin
          if (cmd_aluop_i <= OpLastLegal) begin
            alu_op_d  = cmd_aluop_i;
            alu_a_d   = cmd_a_i;
            alu_b_d   = cmd_b_i;
            alu_inv_d = cmd_inverted_i;
            alu_inc_d = cmd_inc_i;
            cnt_d     = '0;
            state_d   = StIssue;
          end else begin
            status_d   = StatusIllegal;
            rsp_high_d = '0;
            rsp_low_d  = '0;
            state_d    = StResp;
          end
        end
      end
      StIssue: begin
        // done is not looked at here; it may still belong to the previous operation
        if (cnt_q == SettleLast) begin
          cnt_d   = '0;
          state_d = StWait;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWait: begin
        if (alu_done_i) begin
          rsp_high_d = alu_res_high_i;
          rsp_low_d  = alu_res_low_i;
          status_d   = StatusOk;
          cnt_d      = '0;
          state_d    = StResp;
        end else if (cnt_q == TimeoutCnt) begin
          rsp_high_d = '0;
          rsp_low_d  = '0;
          status_d   = StatusTimeout;
          cnt_d      = '0;
          state_d    = StResp;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StResp: begin
        if (rsp_ready_i) begin
          // Zeroing the inputs lets the ALU see a change, so an identical next op restarts
          alu_op_d  = '0;
          alu_a_d   = '0;
          alu_b_d   = '0;
          alu_inv_d = 1'b0;
          alu_inc_d = 1'b0;
          state_d   = StRelease;
        end
      end
      StRelease: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign cmd_ready_o           = (state_q == StIdle) && !rst_i;
  assign rsp_valid_o           = (state_q == StResp);
  assign rsp_high_o            = rsp_high_q;
  assign rsp_low_o             = rsp_low_q;
  assign rsp_status_o          = status_q;
  assign alu_aluop_o           = alu_op_q;
  assign alu_a_o               = alu_a_q;
  assign alu_b_o               = alu_b_q;
  assign alu_output_inverted_o = alu_inv_q;
  assign alu_output_inc_o      = alu_inc_q;

endmodule
